// File: rtl/fetch_decode_buffer.sv
// fetch_decode_buffer
//   IF/ID pipeline register. Latches the fetched word, next PC and in-port data
//   every clock, holds on Stall, injects a NOP bubble on Flush, and joins
//   two-word instructions (opcode word + 16-bit immediate word) into a single
//   decode packet.
//
// Ports:
//   Clk        - clock, rising-edge
//   Rst        - synchronous active-high reset
//   In[63:0]   - fetch bus: [15:0] instr word, [47:16] next PC, [63:48] in-port
//   Stall      - hold all state and outputs
//   Flush      - discard contents, emit bubble (overrides Stall)
//   Out[79:0]  - packet: [15:0] instr, [31:16] imm, [63:32] next PC, [79:64] in-port
//   Valid      - Out carries a real instruction
//   ImmPending - opcode held, waiting for its immediate word
module fetch_decode_buffer #(
    parameter int unsigned IMM_BIT  = 0,
    parameter logic [15:0] NOP_WORD = 16'h0000
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [63:0] In,
    input  logic        Stall,
    input  logic        Flush,
    output logic [79:0] Out,
    output logic        Valid,
    output logic        ImmPending
);

    typedef enum logic [0:0] {
        StFirst,
        StWaitImm
    } state_e;

    localparam logic [79:0] BubblePkt = {64'h0, NOP_WORD};

    state_e      state_q, state_d;
    logic [79:0] out_q, out_d;
    logic        valid_q, valid_d;
    logic [15:0] hold_instr_q, hold_instr_d;
    logic [15:0] hold_port_q, hold_port_d;

    always_comb begin
        state_d      = state_q;
        out_d        = out_q;
        valid_d      = valid_q;
        hold_instr_d = hold_instr_q;
        hold_port_d  = hold_port_q;

        if (Flush) begin
            state_d      = StFirst;
            out_d        = BubblePkt;
            valid_d      = 1'b0;
            hold_instr_d = 16'h0;
            hold_port_d  = 16'h0;
        end else if (!Stall) begin
            case (state_q)
                StFirst: begin
                    if (In[IMM_BIT]) begin
                        hold_instr_d = In[15:0];
                        hold_port_d  = In[63:48];
                        out_d        = BubblePkt;
                        valid_d      = 1'b0;
                        state_d      = StWaitImm;
                    end else begin
                        out_d   = {In[63:48], In[47:16], 16'h0000, In[15:0]};
                        valid_d = 1'b1;
                    end
                end
                StWaitImm: begin
                    // PC taken from the immediate word so return addresses skip it.
                    out_d   = {hold_port_q, In[47:16], In[15:0], hold_instr_q};
                    valid_d = 1'b1;
                    state_d = StFirst;
                end
                default: begin
                    state_d = StFirst;
                end
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q      <= StFirst;
            out_q        <= BubblePkt;
            valid_q      <= 1'b0;
            hold_instr_q <= 16'h0;
            hold_port_q  <= 16'h0;
        end else begin
            state_q      <= state_d;
            out_q        <= out_d;
            valid_q      <= valid_d;
            hold_instr_q <= hold_instr_d;
            hold_port_q  <= hold_port_d;
        end
    end

    assign Out        = out_q;
    assign Valid      = valid_q;
    assign ImmPending = (state_q == StWaitImm);

endmodule
